// File: rtl/div_pkg.sv
// Shared types and helpers for the parametrised sequential divider.
package div_pkg;

  // Widest operand the magnitude helper supports; the divider truncates to WIDTH.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [MAX_W-1:0] DIV0_Q = '1;

  // Two's-complement negate when neg is set; callers truncate to their width,
  // which stays exact because negation is modular.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value,
                                            input logic             neg);
    return neg ? (~value + MAX_W'(1)) : value;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module div_restore_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             d_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;

  always_comb begin
    shifted = {p_in, d_bit};
    q_bit   = (shifted >= (WIDTH+2)'(divisor));
    p_out   = q_bit ? (WIDTH+1)'(shifted - (WIDTH+2)'(divisor))
                    : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/div_nu.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle,
// with valid/ready accept and a held result.
module div_nu
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             is_signed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             out_valid,
  output logic             in_error
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   p_q, p_d;
  logic             sgn_q_q, sgn_q_d;
  logic             sgn_r_q, sgn_r_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             out_valid_q, out_valid_d;
  logic             in_error_q, in_error_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic [WIDTH:0]   step_p;
  logic             step_q;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_q),
    .d_bit   (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .p_out   (step_p),
    .q_bit   (step_q)
  );

  // dvd_q holds the dividend magnitude and fills with quotient bits from the LSB.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    p_d         = p_q;
    sgn_q_d     = sgn_q_q;
    sgn_r_d     = sgn_r_q;
    zero_d      = zero_q;
    q_d         = q_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    in_error_d  = in_error_q;
    accept      = in_valid && in_ready_q;

    case (state_q)
      IDLE, DONE: begin
        if (zero_q) begin
          q_d         = WIDTH'(DIV0_Q);
          r_d         = dvd_q;
          out_valid_d = 1'b1;
          in_error_d  = 1'b1;
          zero_d      = 1'b0;
        end
        // A new accept overrides any pending divide-by-zero result.
        if (accept) begin
          out_valid_d = 1'b0;
          in_error_d  = 1'b0;
          if (Y == '0) begin
            state_d = DONE;
            zero_d  = 1'b1;
            dvd_d   = X;
          end else begin
            state_d = CALC;
            zero_d  = 1'b0;
            dvd_d   = WIDTH'(abs_w(MAX_W'(X), is_signed && X[WIDTH-1]));
            dvs_d   = WIDTH'(abs_w(MAX_W'(Y), is_signed && Y[WIDTH-1]));
            sgn_q_d = is_signed && (X[WIDTH-1] ^ Y[WIDTH-1]);
            sgn_r_d = is_signed && X[WIDTH-1];
            p_d     = '0;
            cnt_d   = CNT_W'(WIDTH);
          end
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          p_d   = step_p;
          dvd_d = {dvd_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          q_d         = WIDTH'(abs_w(MAX_W'(dvd_q), sgn_q_q));
          r_d         = WIDTH'(abs_w(MAX_W'(p_q[WIDTH-1:0]), sgn_r_q));
          out_valid_d = 1'b1;
          in_error_d  = 1'b0;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != CALC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      sgn_q_q     <= 1'b0;
      sgn_r_q     <= 1'b0;
      zero_q      <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      in_error_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      p_q         <= p_d;
      sgn_q_q     <= sgn_q_d;
      sgn_r_q     <= sgn_r_d;
      zero_q      <= zero_d;
      q_q         <= q_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      in_error_q  <= in_error_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign Q         = q_q;
  assign R         = r_q;
  assign out_valid = out_valid_q;
  assign in_error  = in_error_q;
  assign in_ready  = in_ready_q;

endmodule
